// File: rtl/taxi_timer_pkg.sv
// Shared constants for the multi-channel timer.
//   MODE_ONESHOT / MODE_PERIODIC : per-channel mode bit encoding
//   DEF_*                         : default parameter values for multi_timer
//   idx_width()                   : channel-index width, never less than 1
package taxi_timer_pkg;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  localparam int unsigned DEF_DW  = 8;
  localparam int unsigned DEF_CH  = 4;
  localparam int unsigned DEF_MAX = 14;
  localparam int unsigned DEF_PSW = 8;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: counter, period register, running status and sticky irq.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   tick              shared time base strobe
//   enable, mode      run enable; mode 0 = one-shot, 1 = periodic
//   load, load_val    period write strobe (already decoded) and value
//   irq_ack           clears irq
//   irq, running      sticky expiry flag; not-expired status
module timer_channel
  import taxi_timer_pkg::*;
#(
  parameter int unsigned DW  = DEF_DW,
  parameter int unsigned MAX = DEF_MAX
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          enable,
  input  logic          mode,
  input  logic          load,
  input  logic [DW-1:0] load_val,
  input  logic          irq_ack,
  output logic          irq,
  output logic          running
);

  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] per_q, per_d;
  logic          run_q, run_d;
  logic          irq_q, irq_d;
  logic          fire;

  always_comb begin
    cnt_d = cnt_q;
    per_d = per_q;
    run_d = run_q;
    fire  = 1'b0;
    if (tick && enable && run_q) begin
      if (cnt_q == per_q) begin
        fire = 1'b1;
        // Mode is only consulted here, so a mid-count change lands at expiry.
        if (mode == MODE_PERIODIC) begin
          cnt_d = '0;
        end else begin
          run_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // A load overrides the expiry update but the expiry still raises irq.
    if (load) begin
      per_d = load_val;
      cnt_d = '0;
      run_d = 1'b1;
    end
    // Set dominates a simultaneous acknowledge.
    irq_d = (irq_q & ~irq_ack) | fire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      per_q <= DW'(MAX);
      run_q <= 1'b1;
      irq_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      per_q <= per_d;
      run_q <= run_d;
      irq_q <= irq_d;
    end
  end

  assign irq     = irq_q;
  assign running = run_q;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel timer: CH independent timer_channel instances, period-write
// decode and an optional shared prescaler.
// Optional feature macro: TIMER_PRESCALE_EN (adds the prescale port and a
// PSW-bit tick divider; otherwise every clock cycle is a tick).
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   enable, mode                     per-channel run enable and mode
//   load_valid, load_ch, load_val    single-cycle period write
//   irq_ack                          per-channel irq clear
//   prescale                         tick divisor minus one (macro only)
//   irq, running                     per-channel sticky irq and status
module multi_timer
  import taxi_timer_pkg::*;
#(
  parameter int unsigned DW  = DEF_DW,
  parameter int unsigned CH  = DEF_CH,
  parameter int unsigned MAX = DEF_MAX,
  parameter int unsigned PSW = DEF_PSW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CH-1:0]             enable,
  input  logic [CH-1:0]             mode,
  input  logic                      load_valid,
  input  logic [idx_width(CH)-1:0]  load_ch,
  input  logic [DW-1:0]             load_val,
  input  logic [CH-1:0]             irq_ack,
`ifdef TIMER_PRESCALE_EN
  input  logic [PSW-1:0]            prescale,
`endif
  output logic [CH-1:0]             irq,
  output logic [CH-1:0]             running
);

  logic tick;

`ifdef TIMER_PRESCALE_EN
  logic [PSW-1:0] pcnt_q, pcnt_d;

  // ">=" also restarts the divider when prescale drops below the count.
  always_comb begin
    tick   = (pcnt_q >= prescale);
    pcnt_d = tick ? '0 : pcnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end
`else
  logic unused_psw;
  assign unused_psw = (PSW == 0);
  assign tick       = 1'b1;
`endif

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic load_hit;
    // Only indices below CH can match, so out-of-range writes drop out.
    assign load_hit = load_valid && (32'(load_ch) == i);

    timer_channel #(
      .DW  (DW),
      .MAX (MAX)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .enable   (enable[i]),
      .mode     (mode[i]),
      .load     (load_hit),
      .load_val (load_val),
      .irq_ack  (irq_ack[i]),
      .irq      (irq[i]),
      .running  (running[i])
    );
  end

endmodule

// File: tb/tb_multi_timer.sv
module tb_multi_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] enable = '0;
  logic [3:0] mode = '0;
  logic       load_valid = 1'b0;
  logic [1:0] load_ch = '0;
  logic [7:0] load_val = '0;
  logic [3:0] irq_ack = '0;
  logic [3:0] irq;
  logic [3:0] running;
`ifdef TIMER_PRESCALE_EN
  logic [7:0] prescale = '0;
`endif

  int total = 0;
  int bad = 0;

  multi_timer #(
    .DW  (8),
    .CH  (4),
    .MAX (14),
    .PSW (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mode       (mode),
    .load_valid (load_valid),
    .load_ch    (load_ch),
    .load_val   (load_val),
    .irq_ack    (irq_ack),
`ifdef TIMER_PRESCALE_EN
    .prescale   (prescale),
`endif
    .irq        (irq),
    .running    (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] en;
    logic [3:0] mode;
    logic       lv;
    logic [1:0] lch;
    logic [7:0] lval;
    logic [3:0] ack;
    logic [3:0] eirq;
    logic [3:0] erun;
  } vec_t;

  vec_t vecs[18];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic idle();
    enable = '0;
    mode = '0;
    load_valid = 1'b0;
    load_ch = '0;
    load_val = '0;
    irq_ack = '0;
  endtask

  // Leaves rst low; the caller's next step() is the first counting edge.
  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    //          rst   en     mode   lv    lch    lval   ack    eirq   erun
    vecs[0]  = '{1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'hF};
    vecs[1]  = '{1'b1, 4'hF, 4'h0, 1'b1, 2'd0, 8'd0, 4'h0, 4'h0, 4'hF};
    vecs[2]  = '{1'b0, 4'h1, 4'h1, 1'b1, 2'd0, 8'd0, 4'h0, 4'h0, 4'hF};
    vecs[3]  = '{1'b0, 4'h1, 4'h1, 1'b0, 2'd0, 8'd0, 4'h0, 4'h1, 4'hF};
    vecs[4]  = '{1'b0, 4'h1, 4'h1, 1'b0, 2'd0, 8'd0, 4'h1, 4'h1, 4'hF};
    vecs[5]  = '{1'b0, 4'h0, 4'h1, 1'b0, 2'd0, 8'd0, 4'h1, 4'h0, 4'hF};
    vecs[6]  = '{1'b0, 4'h1, 4'h0, 1'b0, 2'd0, 8'd0, 4'h0, 4'h1, 4'hE};
    vecs[7]  = '{1'b0, 4'h1, 4'h0, 1'b0, 2'd0, 8'd0, 4'h1, 4'h0, 4'hE};
    vecs[8]  = '{1'b0, 4'h8, 4'h0, 1'b1, 2'd3, 8'd1, 4'h0, 4'h0, 4'hE};
    vecs[9]  = '{1'b0, 4'h8, 4'h0, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'hE};
    vecs[10] = '{1'b0, 4'h8, 4'h0, 1'b1, 2'd3, 8'd5, 4'h0, 4'h8, 4'hE};
    vecs[11] = '{1'b0, 4'h8, 4'h0, 1'b0, 2'd0, 8'd0, 4'h8, 4'h0, 4'hE};
    vecs[12] = '{1'b0, 4'h8, 4'h0, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'hE};
    vecs[13] = '{1'b0, 4'h8, 4'h0, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'hE};
    vecs[14] = '{1'b0, 4'h8, 4'h0, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'hE};
    vecs[15] = '{1'b0, 4'h8, 4'h0, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'hE};
    vecs[16] = '{1'b0, 4'h8, 4'h0, 1'b0, 2'd0, 8'd0, 4'h0, 4'h8, 4'h6};
    vecs[17] = '{1'b0, 4'h0, 4'h0, 1'b1, 2'd0, 8'd2, 4'h0, 4'h8, 4'h7};

    // Reset state and periodic ch0 with the default period of 14.
    do_reset();
    check("rst_irq", irq, 4'h0);
    check("rst_running", running, 4'hF);
    enable = 4'h1;
    mode = 4'h1;
    repeat (14) step();
    check("per_before", irq, 4'h0);
    step();
    check("per_fire", irq, 4'h1);
    check("per_running", running, 4'hF);
    irq_ack = 4'h1;
    step();
    irq_ack = 4'h0;
    check("per_ack", irq, 4'h0);
    repeat (13) step();
    check("per_before2", irq, 4'h0);
    step();
    check("per_fire2", irq, 4'h1);

    // Enable dropped for 4 cycles at cnt=10 delays expiry by 4.
    do_reset();
    enable = 4'h1;
    mode = 4'h1;
    repeat (10) step();
    enable = 4'h0;
    repeat (4) step();
    check("pause_running", running, 4'hF);
    enable = 4'h1;
    repeat (4) step();
    check("pause_before", irq, 4'h0);
    step();
    check("pause_fire", irq, 4'h1);

    // One-shot ch1 with period 3, then reload.
    do_reset();
    enable = 4'h2;
    load_valid = 1'b1;
    load_ch = 2'd1;
    load_val = 8'd3;
    step();
    load_valid = 1'b0;
    repeat (3) step();
    check("os_before", irq, 4'h0);
    check("os_before_run", running, 4'hF);
    step();
    check("os_fire", irq, 4'h2);
    check("os_done", running, 4'hD);
    repeat (2) step();
    check("os_hold_irq", irq, 4'h2);
    check("os_hold_run", running, 4'hD);
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    check("os_reload_run", running, 4'hF);
    check("os_reload_irq", irq, 4'h2);
    irq_ack = 4'h2;
    step();
    irq_ack = 4'h0;
    check("os_ack", irq, 4'h0);
    repeat (2) step();
    check("os_before2", irq, 4'h0);
    step();
    check("os_fire2", irq, 4'h2);
    check("os_done2", running, 4'hD);

    // Ack on the expiry cycle of ch2 loses to the set.
    do_reset();
    enable = 4'h4;
    mode = 4'h4;
    load_valid = 1'b1;
    load_ch = 2'd2;
    load_val = 8'd2;
    step();
    load_valid = 1'b0;
    repeat (2) step();
    check("ack_before", irq, 4'h0);
    irq_ack = 4'h4;
    step();
    check("ack_same", irq, 4'h4);
    step();
    irq_ack = 4'h0;
    check("ack_late", irq, 4'h0);
    step();
    check("ack_before2", irq, 4'h0);
    step();
    check("ack_fire2", irq, 4'h4);

    // Table: reset dominance, period 0, mode change, load vs expiry.
    for (int i = 0; i < 18; i++) begin
      rst = vecs[i].rst;
      enable = vecs[i].en;
      mode = vecs[i].mode;
      load_valid = vecs[i].lv;
      load_ch = vecs[i].lch;
      load_val = vecs[i].lval;
      irq_ack = vecs[i].ack;
      step();
      check($sformatf("vec%0d_irq", i), irq, vecs[i].eirq);
      check($sformatf("vec%0d_running", i), running, vecs[i].erun);
    end
    idle();

`ifdef TIMER_PRESCALE_EN
    // Tick every 4 clocks, period 2: expiry on the 12th edge.
    do_reset();
    prescale = 8'd3;
    enable = 4'h1;
    mode = 4'h1;
    load_valid = 1'b1;
    load_ch = 2'd0;
    load_val = 8'd2;
    step();
    load_valid = 1'b0;
    repeat (10) step();
    check("ps_before", irq, 4'h0);
    step();
    check("ps_fire", irq, 4'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("ps_rst_irq", irq, 4'h0);
    check("ps_rst_running", running, 4'hF);
    prescale = 8'd0;
    idle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
